// File: rtl/compare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : compare_pkg
// Description : Shared relation and persistence-state encodings for compare_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package compare_pkg;

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_GT = 2'd1;
    localparam logic [1:0] CMP_LT = 2'd2;
    localparam logic [1:0] CMP_NE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_FIRED  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/compare_channel.sv
`default_nettype none
// ============================================================================
// Module      : compare_channel
// Description : One comparator lane with persistence counter and sticky event.
// Revision    : 1.0 - initial release
// ============================================================================
module compare_channel
    import compare_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HOLD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      data,
    input  logic [WIDTH-1:0]      ref_data,
    input  logic [1:0]            mode,
    input  logic [HOLD_WIDTH-1:0] hold_count,
    output logic                  match,
    output logic                  fired,
    output logic [HOLD_WIDTH-1:0] count
);

    localparam logic [HOLD_WIDTH-1:0] c_count_max = '1;

    state_t                r_state;
    logic [HOLD_WIDTH-1:0] r_count;
    logic                  r_match;
    logic                  r_fired;

    logic                  w_hit;
    logic [HOLD_WIDTH:0]   w_count_inc;
    logic [HOLD_WIDTH:0]   w_hold_eff;
    logic [HOLD_WIDTH-1:0] w_count_next;
    logic                  w_reach;

    always_comb begin
        w_hit = 1'b0;
        case (mode)
            CMP_EQ:  w_hit = (data == ref_data);
            CMP_GT:  w_hit = (data >  ref_data);
            CMP_LT:  w_hit = (data <  ref_data);
            CMP_NE:  w_hit = (data != ref_data);
            default: w_hit = 1'b0;
        endcase
    end

    // A programmed hold of zero behaves as one; compare at HOLD_WIDTH+1 bits so
    // count+1 can never wrap past the threshold.
    assign w_count_inc  = {1'b0, r_count} + (HOLD_WIDTH+1)'(1);
    assign w_hold_eff   = (hold_count == '0) ? (HOLD_WIDTH+1)'(1) : {1'b0, hold_count};
    assign w_reach      = (w_count_inc >= w_hold_eff);
    assign w_count_next = (r_count == c_count_max) ? r_count : w_count_inc[HOLD_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_match <= 1'b0;
            r_fired <= 1'b0;
        end else begin
            if (in_valid) begin
                r_match <= w_hit;
            end
            if (clear) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_fired <= 1'b0;
            end else if (in_valid) begin
                case (r_state)
                    ST_IDLE, ST_ARMING: begin
                        if (w_hit) begin
                            r_count <= w_count_next;
                            if (w_reach) begin
                                r_state <= ST_FIRED;
                                r_fired <= 1'b1;
                            end else begin
                                r_state <= ST_ARMING;
                            end
                        end else begin
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_FIRED: begin
                        r_state <= ST_FIRED;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_fired <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign match = r_match;
    assign fired = r_fired;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/compare_seq.sv
`default_nettype none
// ============================================================================
// Module      : compare_seq
// Description : Multi-channel registered comparator with persistence filtering.
// Revision    : 1.0 - initial release
// ============================================================================
module compare_seq
    import compare_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int HOLD_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [WIDTH-1:0]             ref_data,
    input  logic [1:0]                   mode,
    input  logic [HOLD_WIDTH-1:0]        hold_count,
    input  logic                         clear,
    output logic                         out_valid,
    output logic [CHANNELS-1:0]          match,
    // Sticky fired flags; "event" itself is a reserved word in SystemVerilog.
    output logic [CHANNELS-1:0]          events,
    output logic                         any_event,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_ch
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  r_out_valid;
    logic [CHANNELS-1:0]   w_match;
    logic [CHANNELS-1:0]   w_events;
    logic [CH_W-1:0]       w_first;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [HOLD_WIDTH-1:0] w_count;

            compare_channel #(
                .WIDTH      (WIDTH),
                .HOLD_WIDTH (HOLD_WIDTH)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .clear      (clear),
                .in_valid   (in_valid),
                .data       (in_data[c*WIDTH +: WIDTH]),
                .ref_data   (ref_data),
                .mode       (mode),
                .hold_count (hold_count),
                .match      (w_match[c]),
                .fired      (w_events[c]),
                .count      (w_count)
            );
        end
    endgenerate

    // Scan high to low so the lowest set index is the last to write.
    always_comb begin
        w_first = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_events[c]) begin
                w_first = CH_W'(c);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign match     = w_match;
    assign events    = w_events;
    assign any_event = |w_events;
    assign first_ch  = w_first;

endmodule
`default_nettype wire

// File: doc/compare_seq.md
# compare_seq

Multi-channel registered comparator: the sequential successor to the combinational `compare` block. Each of `CHANNELS` unsigned inputs is compared against a shared reference under a selectable relation. A per-channel persistence counter raises a sticky event only after `hold_count` consecutive matching samples. It sits between a sampled data source and the control/interrupt logic, filtering single-sample glitches out of threshold decisions.

## Interface
- `WIDTH`, default 8: bit width of each data channel and of the reference.
- `CHANNELS`, default 4: number of independent compare channels.
- `HOLD_WIDTH`, default 4: width of the persistence count and of each channel counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  qualifies `in_data` for this cycle.
- `in_data`  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH], unsigned.
- `ref_data`  in  WIDTH  shared unsigned reference.
- `mode`  in  2  relation: 0 EQ (d==ref), 1 GT (d>ref), 2 LT (d<ref), 3 NE (d!=ref).
- `hold_count`  in  HOLD_WIDTH  consecutive matches required; 0 is treated as 1.
- `clear`  in  1  clears all counters and sticky events.
- `out_valid`  out  1  registered copy of `in_valid`.
- `match`  out  CHANNELS  registered raw compare result of the last sample.
- `event`  out  CHANNELS  sticky per-channel fired flag.
- `any_event`  out  1  OR of `event`.
- `first_ch`  out  $clog2(CHANNELS) (min 1)  lowest index with `event` set; 0 when none.

## Operation
- Per-channel FSM states:
  - IDLE: count = 0.
  - ARMING: 0 < count < hold.
  - FIRED: sticky.
- On a cycle with `in_valid` = 1 and `clear` = 0, each channel evaluates `mode` on its input against `ref_data`:
  - Match in IDLE/ARMING: count increments. When count+1 ≥ effective hold, go to FIRED.
  - Non-match in ARMING: count resets to 0, go to IDLE. Non-match in IDLE stays in IDLE.
  - FIRED: ignores matches and non-matches. Only `clear` or `reset` leaves it.
- `in_valid` = 0: counters and states hold. A gap does not break a consecutive run.
- Counters saturate at 2^HOLD_WIDTH−1 and never wrap.
- `mode`, `ref_data` and `hold_count` are sampled every valid cycle. A change applies to the current sample and does not reset counters.
  - Lowering `hold_count` below a channel's current count fires that channel on its next match.
- `clear` has priority over a same-cycle sample. All channels go to IDLE, count = 0, `event` = 0, and that cycle's sample is discarded for persistence purposes.
  - `match`/`out_valid` still register the sample.
- `first_ch`/`any_event` are combinational from the `event` register.

## Timing
- Reset values: `out_valid` = 0, `match` = 0, `event` = 0, `any_event` = 0, `first_ch` = 0, all counters 0, all FSMs IDLE.
- `reset` takes priority over `clear` and `in_valid`. Asserting it mid-run discards all history on the next edge.
- Latency: sample accepted at edge t gives `out_valid`/`match` at t+1.
  - The sample completing the run sets `event` at t+1, the same cycle its `match` bit appears.
- `hold_count` = 1 (or 0): `event` rises with the first `match`.
- No backpressure; one sample per cycle at full rate.

## Structure
- Shared package `compare_pkg`:
  - mode encodings `CMP_EQ`, `CMP_GT`, `CMP_LT`, `CMP_NE`;
  - FSM state encodings `ST_IDLE`, `ST_ARMING`, `ST_FIRED`.
- Sub-module `compare_channel`, instantiated once per channel through a generate loop. It holds the comparator, counter, FSM and match/event registers.
- The top level contains the `out_valid` register, the `any_event` OR and the lowest-index priority encoder for `first_ch`.

## Test plan
- Reset/idle: hold `reset` high 3 cycles, then release with `in_valid` = 0 → all outputs 0 and no change over 10 cycles.
- EQ persistence: WIDTH=8, mode=EQ, ref=0x20, hold=3, ch0 driven 0x1E,0x1F,0x20,0x21 repeatedly (ramp) → `match[0]` single-cycle pulses and `event[0]` never set. Then ch0 = 0x20 for 3 valid cycles → `event[0]` rises at the cycle after the 3rd sample; `first_ch` = 0 and `any_event` = 1.
- Run broken vs. gap: GT, ref=0x80, hold=4, ch2 = 0x90,0x90,0x10,0x90 → no event. Then ch2 = 0x90,0x90 followed by 5 cycles `in_valid` = 0, then 0x90,0x90 → `event[2]` set after the 4th valid match.
- Priority encoder: ch3 fires first, ch1 fires later → `first_ch` = 3, then 1. Assert `clear` → `event` = 0 and `first_ch` = 0 on the next cycle.
- Simultaneous clear and completing sample: hold=2, one match, then a second match with `clear` = 1 → `event` stays 0 and the counter is 0. The next two matches fire.
- Saturation and reset mid-run: HOLD_WIDTH=4, hold=15, NE, continuous mismatching data for 20 cycles → `event` set at sample 15 and the counter stays at 15. Pulse `reset` during a 2nd run at count 7 → all state returns to reset values on the next edge.
